// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
//   Definitions shared across the spiking pipeline.
//   - SNN_W          : native magnitude width of the pipeline.
//   - SNN_THRESHOLD  : neuron firing threshold. A neuron fed magnitude m fires
//                      m/SNN_THRESHOLD spikes per cycle, so a window of this
//                      many cycles recovers m exactly.
//   - dec_state_t    : state encoding of spike_rate_decoder.
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int         SNN_W         = 8;
    localparam logic [7:0] SNN_THRESHOLD = 8'd128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } dec_state_t;

endpackage

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
//   Counts spikes over a programmable window of clock cycles and presents the
//   count as a magnitude through a valid/ready handshake.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   spike_in    in   spike from the upstream neuron, sampled while counting
//   start       in   request to begin a window (accepted in IDLE, or in DONE
//                    together with a completed handshake)
//   window_len  in   window length in cycles, latched on accept; 0 selects
//                    DEFAULT_WINDOW
//   rate_out    out  spike count of the completed window
//   rate_valid  out  rate_out holds a result
//   rate_ready  in   consumer accepts the result
//   busy        out  high while counting or holding a result
//   state_dbg   out  current FSM state, for observation only
//
// Handshake: a result transfers on every rising edge where
//   rate_valid && rate_ready. While rate_valid is high and rate_ready is low,
//   rate_out is held stable. rate_valid never drops without a transfer except
//   on reset.
// ---------------------------------------------------------------------------
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W          = SNN_W,
    parameter int DEFAULT_WINDOW = int'(SNN_THRESHOLD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_in,
    input  logic             start,
    input  logic [CNT_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             busy,
    output dec_state_t       state_dbg
);

    localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(DEFAULT_WINDOW);
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;     // samples still to take in this window
    logic [CNT_W-1:0] spk_q, spk_d;     // spikes seen so far in this window
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             hs;
    logic             accept;
    logic [CNT_W-1:0] len_sel;
    logic [CNT_W-1:0] spk_inc;

    assign hs      = valid_q && rate_ready;
    assign accept  = start && ((state_q == IDLE) || ((state_q == DONE) && hs));
    assign len_sel = (window_len == '0) ? DEF_LEN : window_len;
    assign spk_inc = {{(CNT_W-1){1'b0}}, spike_in};

    // Next-state logic for the whole decoder.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        spk_d   = spk_q;
        rate_d  = rate_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
            end
            COUNT: begin
                spk_d = spk_q + spk_inc;
                cyc_d = cyc_q - ONE;
                // Counter at 1 means this edge takes the last sample, so the
                // published result must already include it.
                if (cyc_q == ONE) begin
                    state_d = DONE;
                    rate_d  = spk_q + spk_inc;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (hs) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Accepting a start overrides the DONE->IDLE move so back-to-back
        // windows have no idle bubble.
        if (accept) begin
            state_d = COUNT;
            cyc_d   = len_sel;
            spk_d   = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            spk_q   <= '0;
            rate_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            spk_q   <= spk_d;
            rate_q  <= rate_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign rate_out   = rate_q;
    assign rate_valid = valid_q;
    assign busy       = busy_q;
    assign state_dbg  = state_q;

    // A window is at most 2^CNT_W-1 samples, so the spike count cannot wrap.
    count_no_wrap: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == COUNT && spike_in) |-> (spk_q != '1)
    );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_decoder
//   Directed windows with hand-computed results, a stall / back-to-back /
//   reset-abort sequence, then randomized traffic. A behavioural model tracks
//   the outstanding window as "samples left + running sum" and a compare
//   process checks busy/rate_valid/rate_out on every falling edge.
// ---------------------------------------------------------------------------
module tb_spike_rate_decoder;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         spike_in = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] window_len = '0;
    logic         rate_ready = 1'b0;
    logic [W-1:0] rate_out;
    logic         rate_valid;
    logic         busy;
    snn_pkg::dec_state_t state_dbg;

    spike_rate_decoder #(.CNT_W(W), .DEFAULT_WINDOW(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .start      (start),
        .window_len (window_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A window is fully described by how many samples are left and the sum so
    // far; a finished window is a pending result until the consumer takes it.
    int           m_left;
    int           m_sum;
    bit           m_valid;
    logic [W-1:0] m_rate;
    logic [W-1:0] exp_q[$];   // results in the order the consumer must see them

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  = 0;
            m_sum   = 0;
            m_valid = 0;
            m_rate  = '0;
            exp_q.delete();
        end else begin
            bit idle, took;
            idle = (m_left == 0) && !m_valid;
            took = m_valid && rate_ready;
            if (took) begin
                m_valid = 0;
                void'(exp_q.pop_front());
            end
            if (m_left > 0) begin
                m_sum  = m_sum + int'(spike_in);
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_valid = 1;
                    m_rate  = W'(m_sum);
                    exp_q.push_back(W'(m_sum));
                end
            end
            if (start && (idle || took)) begin
                m_left = (window_len == 0) ? 128 : int'(window_len);
                m_sum  = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, (m_left > 0) || m_valid);
            chk("rate_valid", rate_valid, m_valid);
            if (m_valid) begin
                chk("rate_out", rate_out, m_rate);
                chk("rate_out_q", rate_out, (exp_q.size() > 0) ? exp_q[0] : 'x);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = no spikes, 1 = always spike, 2 = alternate starting with 1,
    //       3 = rate-coded neuron of magnitude 64 (threshold 128)
    int nrn_acc;
    function automatic logic next_spike(input int mode, input int k);
        logic s;
        case (mode)
            0: s = 1'b0;
            1: s = 1'b1;
            2: s = (k % 2 == 1);
            default: begin
                nrn_acc = nrn_acc + 64;
                s = (nrn_acc >= 128);
                if (s) nrn_acc = nrn_acc - 128;
            end
        endcase
        return s;
    endfunction

    // Counts the edges after the accepting edge until rate_valid is seen.
    task automatic wait_result(input string name, input int mode, input int exp_edges,
                               input logic [W-1:0] exp_rate);
        int k;
        int busy_bad;
        k = 0;
        busy_bad = 0;
        nrn_acc = 0;
        while (!rate_valid && k < 400) begin
            spike_in = next_spike(mode, k + 1);
            tick();
            k++;
            if (!rate_valid && !busy) busy_bad++;
        end
        spike_in = 1'b0;
        chk({name, "_latency"}, k, exp_edges);
        chk({name, "_rate"}, rate_out, exp_rate);
        chk({name, "_busy_window"}, busy_bad, 0);
    endtask

    task automatic start_window(input logic [W-1:0] len);
        start = 1'b1;
        window_len = len;
        tick();
        start = 1'b0;
        window_len = $urandom_range(0, 255);   // must not affect running window
    endtask

    task automatic take_result(input string name);
        rate_ready = 1'b1;
        tick();
        rate_ready = 1'b0;
        chk({name, "_valid_drop"}, rate_valid, 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] held;
        int bad;

        repeat (3) tick();
        chk("reset_rate_out", rate_out, 0);
        chk("reset_valid", rate_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_state", state_dbg, snn_pkg::IDLE);
        rst_n = 1'b1;
        tick();

        // len 10, spike held high: result 10 after 10 sampling edges
        start_window(8'd10);
        chk("busy_after_start", busy, 1);
        wait_result("len10", 1, 10, 8'd10);
        take_result("len10");

        // default window with a magnitude-64 neuron upstream
        start_window(8'd0);
        wait_result("neuron64", 3, 128, 8'd64);
        take_result("neuron64");

        // largest window, no wrap
        start_window(8'd255);
        wait_result("len255", 1, 255, 8'd255);
        take_result("len255");

        // minimum window
        start_window(8'd1);
        wait_result("len1_zero", 0, 1, 8'd0);
        take_result("len1_zero");
        start_window(8'd1);
        wait_result("len1_one", 1, 1, 8'd1);

        // stall: result held, spikes and start pulses ignored
        held = rate_out;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            spike_in = $urandom_range(0, 1);
            start = (i % 3 == 0);
            window_len = 8'd5;
            tick();
            if (rate_out !== held || !rate_valid || !busy) bad++;
        end
        start = 1'b0;
        spike_in = 1'b0;
        chk("stall_bad_cycles", bad, 0);
        take_result("stall");

        // back-to-back: handshake and start in the same cycle
        start_window(8'd4);
        wait_result("b2b_first", 2, 4, 8'd2);
        rate_ready = 1'b1;
        start = 1'b1;
        window_len = 8'd4;
        tick();
        rate_ready = 1'b0;
        start = 1'b0;
        chk("b2b_valid_drop", rate_valid, 0);
        chk("b2b_no_bubble", busy, 1);
        wait_result("b2b_second", 2, 4, 8'd2);
        take_result("b2b");

        // asynchronous reset mid-window
        start_window(8'd128);
        for (int i = 0; i < 50; i++) begin
            spike_in = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("abort_rate_out", rate_out, 0);
        chk("abort_valid", rate_valid, 0);
        chk("abort_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        spike_in = 1'b0;
        tick();
        start_window(8'd10);
        wait_result("after_abort", 2, 10, 8'd5);
        take_result("after_abort");

        // randomized traffic, judged by the model and compare process
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 19))
                0:       window_len = 8'd0;
                1:       window_len = 8'd255;
                default: window_len = W'($urandom_range(1, 12));
            endcase
            rate_ready = ($urandom_range(0, 2) != 0);
            spike_in = $urandom_range(0, 1);
            tick();
        end
        start = 1'b0;
        rate_ready = 1'b1;
        repeat (300) tick();
        chk("drain_idle", busy, 0);
        chk("drain_model_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
